dmem_lsu_ctrl: RTL

- Load/store sequencer between the RV32I execute stage and the word-wide, single-port, synchronous-read data memory.
- Converts byte/halfword/word loads and stores (funct3-encoded) into word-only memory cycles.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Handles one request at a time: valid/ready request side, one-cycle response pulse.

---
 rtl/dmem_lsu_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dmem_lsu_ctrl.sv
// RV32I load/store sequencer: sub-word stores via read-modify-write on a word-wide sync-read memory.
// Optional misalignment/illegal-funct3 trap: define LSU_MISALIGN_TRAP_EN.
module dmem_lsu_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rw,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [ADDR_W+1:0]  r_addr;
  logic [31:0]        r_wbuf;
  logic [31:0]        r_rdata;

  logic               w_illegal;
  logic [2:0]         w_f3;
  logic               w_sw;
  logic               w_trap;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;
  logic               w_unused_addr;

  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  // Stores only allow B/H/W; loads additionally allow BU/HU. Illegal codes collapse to W.
  assign w_illegal = req_we ? (req_funct3[2] | (req_funct3[1] & req_funct3[0]))
                            : ((req_funct3[1] & req_funct3[0]) | (req_funct3[2] & req_funct3[1]));
  assign w_f3      = w_illegal ? 3'b010 : req_funct3;
  assign w_sw      = req_we && (w_f3[1:0] == 2'b10);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_err;
  assign w_misalign = ((w_f3[1:0] == 2'b01) && req_addr[0]) ||
                      ((w_f3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_trap     = w_illegal | w_misalign;
  assign resp_err   = r_err && (r_state == S_RESP);
`else
  assign w_trap     = 1'b0;
  assign resp_err   = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign mem_rw     = (r_state == S_WR);
  assign mem_addr   = r_addr[ADDR_W+1:2];
  assign mem_wdata  = r_wbuf;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_trap ? S_RESP : (w_sw ? S_WR : S_RD);
      S_RD:    w_next = S_MERGE;
      S_MERGE: w_next = r_we ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_byte   = mem_rdata[7:0];
    w_merged = mem_rdata;
    case (r_addr[1:0])
      2'd0: begin w_byte = mem_rdata[7:0];   w_merged[7:0]   = r_wbuf[7:0]; end
      2'd1: begin w_byte = mem_rdata[15:8];  w_merged[15:8]  = r_wbuf[7:0]; end
      2'd2: begin w_byte = mem_rdata[23:16]; w_merged[23:16] = r_wbuf[7:0]; end
      default: begin w_byte = mem_rdata[31:24]; w_merged[31:24] = r_wbuf[7:0]; end
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // Byte lanes above are overwritten when the store is a halfword.
    if (r_funct3[1:0] == 2'b01) begin
      w_merged = mem_rdata;
      if (r_addr[1]) w_merged[31:16] = r_wbuf[15:0];
      else           w_merged[15:0]  = r_wbuf[15:0];
    end
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wbuf   <= '0;
      r_rdata  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_funct3 <= w_f3;
          r_addr   <= req_addr[ADDR_W+1:0];
          r_wbuf   <= req_wdata;
          if (w_trap) r_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
          r_err    <= w_trap;
`endif
        end
        S_MERGE: begin
          if (r_we) r_wbuf  <= w_merged;
          else      r_rdata <= w_load;
        end
        S_WR:    r_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule
